// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word-aligned reads to a combinational memory and
// buffers returned instructions in a small FIFO presented to decode via valid/ready.
module instr_fetch #(
  parameter int unsigned       AWIDTH    = 32,
  parameter int unsigned       DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000),
  parameter int unsigned       DEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic              mem_read_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [AWIDTH-1:0] out_pc_o,
  output logic [DWIDTH-1:0] out_insn_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] pc_buf   [DEPTH];
  logic [DWIDTH-1:0] insn_buf [DEPTH];
  logic              pop;
  logic              issue;

  always_comb begin
    out_valid_o   = (count_q != '0);
    out_pc_o      = out_valid_o ? pc_buf[rd_ptr_q] : '0;
    out_insn_o    = out_valid_o ? insn_buf[rd_ptr_q] : '0;
    pop           = out_valid_o & out_ready_i;
    // A pop frees a slot at the same edge, so a full buffer can still accept a push.
    issue         = !redirect_i & rst & ((count_q < CW'(DEPTH)) | pop);
    mem_read_en_o = issue;
    mem_addr_o    = pc_q;
  end

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_i) begin
      pc_d     = {redirect_pc_i[AWIDTH-1:2], 2'b00};
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (issue) begin
        pc_d     = pc_q + AWIDTH'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({issue, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= BASE_ADDR;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; count_q gates visibility.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_buf[wr_ptr_q]   <= pc_q;
      insn_buf[wr_ptr_q] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational memory model.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic [31:0] mem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_insn;

  int n_checks = 0;
  int n_errors = 0;
  int issues;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr_o    (mem_addr),
    .mem_read_en_o (mem_read_en),
    .mem_data_i    (mem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_pc_o      (out_pc),
    .out_insn_o    (out_insn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0100_0000: return 32'h1111_1111;
      32'h0100_0004: return 32'h2222_2222;
      32'h0100_0008: return 32'h3333_3333;
      32'h0100_000C: return 32'h4444_4444;
      default:       return (addr * 32'd3) ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  assign mem_data = mem_word(mem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b0;
    @(negedge clk);
    out_ready = ready;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    rst = 1'b0;
    out_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;

    // Reset state
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_insn", out_insn, 0);
    check("rst_rden", mem_read_en, 0);
    check("rst_addr", mem_addr, 32'h0100_0000);

    // Stream: valid one edge after release, then one per cycle
    rst = 1'b1;
    #1;
    check("rel_rden", mem_read_en, 1);
    check("rel_valid", out_valid, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h0100_0000 + 32'(4 * i);
      check("str_valid", out_valid, 1);
      check("str_pc", out_pc, exp_pc);
      check("str_insn", out_insn, mem_word(exp_pc));
      @(negedge clk);
    end

    // Backpressure: exactly DEPTH issues, head stable
    do_reset(1'b0);
    issues = 0;
    for (int i = 0; i < 5; i++) begin
      issues += int'(mem_read_en);
      if (i > 0) begin
        check("bp_head_pc", out_pc, 32'h0100_0000);
        check("bp_head_insn", out_insn, 32'h1111_1111);
      end
      @(negedge clk);
    end
    check("bp_issues", issues, 2);
    check("bp_rden", mem_read_en, 0);
    check("bp_addr", mem_addr, 32'h0100_0008);

    // Release: full buffer pops and pushes every cycle, order preserved
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h0100_0000 + 32'(4 * i);
      check("drain_valid", out_valid, 1);
      check("drain_pc", out_pc, exp_pc);
      check("drain_insn", out_insn, mem_word(exp_pc));
      check("full_rden", mem_read_en, 1);
      check("full_addr", mem_addr, exp_pc + 32'd8);
      @(negedge clk);
    end

    // Redirect with buffer full
    out_ready = 1'b0;
    @(negedge clk);
    check("full_hold_rden", mem_read_en, 0);
    redirect = 1'b1;
    redirect_pc = 32'h0100_0023;
    #1;
    check("redir_rden", mem_read_en, 0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("redir_valid", out_valid, 0);
    check("redir_empty_pc", out_pc, 0);
    check("redir_empty_insn", out_insn, 0);
    check("redir_issue", mem_read_en, 1);
    check("redir_addr", mem_addr, 32'h0100_0020);
    out_ready = 1'b1;
    @(negedge clk);
    check("redir_first_valid", out_valid, 1);
    check("redir_first_pc", out_pc, 32'h0100_0020);
    check("redir_first_insn", out_insn, mem_word(32'h0100_0020));

    // Wrap around the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("wrap_gap_valid", out_valid, 0);
    @(negedge clk);
    check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    check("wrap_insn0", out_insn, mem_word(32'hFFFF_FFFC));
    @(negedge clk);
    check("wrap_pc1", out_pc, 32'h0000_0000);
    check("wrap_insn1", out_insn, mem_word(32'h0000_0000));

    // Back-to-back redirects: last one wins
    redirect = 1'b1;
    redirect_pc = 32'h0100_0100;
    @(negedge clk);
    redirect_pc = 32'h0100_0200;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("b2b_valid", out_valid, 0);
    @(negedge clk);
    check("b2b_pc", out_pc, 32'h0100_0200);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_rden", mem_read_en, 0);
    check("arst_addr", mem_addr, 32'h0100_0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_restart_valid", out_valid, 1);
    check("arst_restart_pc", out_pc, 32'h0100_0000);
    check("arst_restart_insn", out_insn, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the byte-addressed main memory.
- Drives the memory's read port with a word-aligned PC and captures each returned instruction. The memory read is combinational.
- Holds fetched instructions in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes all in-flight instructions.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, instruction/data width.
- BASE_ADDR, 32'h01000000, reset PC; matches the memory base.
- DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_addr_o  output  AWIDTH  byte address to memory; always equals pc_q.
- mem_read_en_o  output  1  memory read enable; high in issue cycles only.
- mem_data_i  input  DWIDTH  combinational read data, little-endian word at mem_addr_o.
- redirect_i  input  1  flush and load a new PC.
- redirect_pc_i  input  AWIDTH  target PC for a redirect.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  decode accepts the head entry.
- out_pc_o  output  AWIDTH  PC of the head entry.
- out_insn_o  output  DWIDTH  instruction of the head entry.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_q=BASE_ADDR, count=0, read/write pointers=0.
  - out_valid_o=0, out_pc_o=0, out_insn_o=0, mem_read_en_o=0, mem_addr_o=BASE_ADDR.
- Combinational signals:
  - pop = out_valid_o & out_ready_i.
  - issue = !redirect_i & rst & (count<DEPTH | pop).
  - mem_read_en_o = issue.
- Issue edge:
  - Push {pc_q, mem_data_i} at the write pointer.
  - pc_q <= pc_q+4, wrapping modulo 2^AWIDTH (0xFFFFFFFC -> 0x00000000).
- Pop edge: advance the read pointer.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, including at count=DEPTH.
- Full, no pop: no issue; pc_q holds; mem_read_en_o=0.
- Empty: out_valid_o=0; out_pc_o and out_insn_o driven 0. There is no bypass: an instruction becomes visible the cycle after its issue edge.
- Latency:
  - First instruction: out_valid_o rises one edge after rst deasserts.
  - Steady state with out_ready_i=1: one instruction per cycle, no bubbles.
- Redirect (priority over issue and pop):
  - In the redirect cycle: mem_read_en_o=0.
  - At the edge: count and pointers cleared, pc_q <= {redirect_pc_i[AWIDTH-1:2], 2'b00}.
  - A handshake that completes in the redirect cycle is counted as accepted by decode, but the buffer is flushed regardless.
  - Next cycle: out_valid_o=0 and an issue at the new PC. The first post-redirect instruction is valid two edges after redirect_i was sampled.
  - Back-to-back redirects: only the last one takes effect.
- Handshake rule: out_pc_o and out_insn_o are stable while out_valid_o=1 and out_ready_i=0.
- Write port: never driven by this block. The integrator ties the memory's write_en_i low.
- Reset mid-stream: buffered entries are discarded immediately; after release, fetch restarts at BASE_ADDR.

Test Plan:
- Stream: preload 0x01000000/04/08/0C with 11111111/22222222/33333333/44444444, out_ready_i=1, release rst.
  - out_valid_o rises after one edge.
  - Outputs are (01000000,11111111) … (0100000C,44444444) on consecutive cycles.
- Backpressure: out_ready_i=0 for 5 cycles.
  - Exactly DEPTH=2 issues, then mem_read_en_o=0 and mem_addr_o holds 01000008.
  - Head stays (01000000,11111111).
  - On out_ready_i=1, 01000000, 01000004, 01000008 appear with no gaps and no duplicates.
- Redirect: with the buffer full, pulse redirect_i, redirect_pc_i=0x01000023.
  - mem_read_en_o=0 that cycle; out_valid_o=0 the next cycle.
  - Next delivered out_pc_o=0x01000020; no pre-redirect PCs are delivered.
- Wrap: redirect to 0xFFFFFFFC → delivered PCs are FFFFFFFC, then 00000000.
- Full with simultaneous pop/push: count=2, out_ready_i=1 → issue continues every cycle, count stays 2, order preserved.
- Async reset mid-stream: drive rst=0 between edges.
  - out_valid_o=0 and mem_read_en_o=0 immediately, without waiting for a clock.
  - After release, first delivered out_pc_o=01000000.
